// File: rtl/display_scan_mux.sv
// rtl/display_scan_mux.sv - time-multiplexed 7-segment digit scanner with blanking gap and per-frame snapshot
// Optional LEADING_ZERO_BLANK_EN: show leading zero digits (except digit 0) as 4'hF.
module display_scan_mux #(
  parameter int N_DIGITS     = 6,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp_mask,
  output logic [3:0]            number,
  output logic [N_DIGITS-1:0]   dig_sel,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (N_DIGITS > 2) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*N_DIGITS-1:0]   snap_digits_q, snap_digits_d;
  logic [N_DIGITS-1:0]     snap_dp_q, snap_dp_d;
  logic [3:0]              number_q, number_d;
  logic [N_DIGITS-1:0]     dig_sel_q, dig_sel_d;
  logic                    dp_q, dp_d;
  logic                    frame_start_q, frame_start_d;

  logic                    slot_end, frame_wrap, visible;
  logic [3:0]              cur_digit;
  logic                    cur_dp;

`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0]     blank_q, blank_d;
  logic [N_DIGITS-1:0]     lead_zero;
  logic                    upper_zero;

  // A digit is blank when it and every more significant digit are zero.
  always_comb begin
    lead_zero  = '0;
    upper_zero = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      upper_zero   = upper_zero && (digits[4*i +: 4] == 4'd0);
      lead_zero[i] = upper_zero;
    end
  end
`endif

  always_comb begin
    cur_digit = 4'd0;
    cur_dp    = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
`ifdef LEADING_ZERO_BLANK_EN
        cur_digit = blank_q[i] ? 4'hF : snap_digits_q[4*i +: 4];
`else
        cur_digit = snap_digits_q[4*i +: 4];
`endif
        cur_dp    = snap_dp_q[i];
      end
    end
  end

  always_comb begin
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    snap_digits_d = snap_digits_q;
    snap_dp_d     = snap_dp_q;
    number_d      = number_q;
    dig_sel_d     = '0;
    dp_d          = 1'b0;
    frame_start_d = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank_d       = blank_q;
`endif
    slot_end   = (cnt_q == CNT_LAST);
    frame_wrap = slot_end && (idx_q == IDX_LAST);
    visible    = (cnt_q >= BLANK_END);

    if (en) begin
      cnt_d = slot_end ? '0 : cnt_q + 1'b1;
      if (slot_end) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      // Capture only at frame wrap so a counter rollover never splits a frame.
      if (frame_wrap) begin
        snap_digits_d = digits;
        snap_dp_d     = dp_mask;
`ifdef LEADING_ZERO_BLANK_EN
        blank_d       = lead_zero;
`endif
      end
      number_d = cur_digit;
      for (int i = 0; i < N_DIGITS; i++) begin
        dig_sel_d[i] = visible && (idx_q == IW'(i));
      end
      dp_d          = cur_dp && visible;
      frame_start_d = (cnt_q == '0) && (idx_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      number_q      <= '0;
      dig_sel_q     <= '0;
      dp_q          <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank_q       <= '0;
`endif
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
      number_q      <= number_d;
      dig_sel_q     <= dig_sel_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
`ifdef LEADING_ZERO_BLANK_EN
      blank_q       <= blank_d;
`endif
    end
  end

  assign number      = number_q;
  assign dig_sel     = dig_sel_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule
